// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS main control.
//   - opcode constants for the supported instruction classes
//   - FSM state encodings (binary; values 13..15 are undefined)
//   - alu_op encodings, shared with the ALU control unit
//   - alu_src_b and pc_src mux select encodings
//   - ctrl_t: the control word produced by mc_ctrl_outdec
// Optional feature macro: MC_MAIN_CONTROL_BNE_EN (adds BNE / BRANCH_NE).
package mc_ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEMADR    = 4'd2,
    ST_MEMRD     = 4'd3,
    ST_MEMWB     = 4'd4,
    ST_MEMWR     = 4'd5,
    ST_EXEC      = 4'd6,
    ST_ALUWB     = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_ADDIEX    = 4'd9,
    ST_ADDIWB    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_BRANCH_NE = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode that DECODE knows how to dispatch.
  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MC_MAIN_CONTROL_BNE_EN
    legal = legal || (op == OP_BNE);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state -> control-word decoder.
// Ports:
//   state     in  current FSM state
//   opcode    in  IR opcode field (only used for illegal_op in DECODE)
//   zero      in  ALU zero flag (branch decision)
//   mem_ready in  memory completes this cycle (FETCH IR/PC load)
//   ctrl      out full control word; fields not set by a state stay 0
// Optional feature macro: MC_MAIN_CONTROL_BNE_EN (decodes BRANCH_NE).
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC+4 are only captured in the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      ST_DECODE: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_is_legal(opcode);
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
`ifdef MC_MAIN_CONTROL_BNE_EN
      ST_BRANCH_NE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_en     = !zero;
      end
`endif
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback, one instruction at a time.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   opcode             instr[31:26] from the IR
//   zero               ALU zero flag (used in BRANCH / BRANCH_NE)
//   mem_ready          memory completes the current access this cycle
//   mem_req..illegal_op datapath control outputs (0 while rst is high)
//   state_o            current state for debug (FETCH while rst is high)
// Optional feature macro: MC_MAIN_CONTROL_BNE_EN (BNE support).
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            iord,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic [1:0]      pc_src,
  output logic            pc_en,
  output logic [1:0]      alu_op,
  output logic            illegal_op,
  output logic [ST_W-1:0] state_o
);

  state_t     state_reg;
  state_t     state_next;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_out;
  logic [5:0] op;

  assign op = 6'(opcode);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = ST_FETCH;
    unique case (state_reg)
      ST_FETCH:  state_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_next = ST_MEMADR;
        else if (op == OP_RTYPE)        state_next = ST_EXEC;
        else if (op == OP_BEQ)          state_next = ST_BRANCH;
        else if (op == OP_ADDI)         state_next = ST_ADDIEX;
        else if (op == OP_J)            state_next = ST_JUMP;
`ifdef MC_MAIN_CONTROL_BNE_EN
        else if (op == OP_BNE)          state_next = ST_BRANCH_NE;
`endif
        else                            state_next = ST_FETCH;
      end
      // Re-check the opcode; anything but LW/SW here is treated as a no-op.
      ST_MEMADR: begin
        if (op == OP_LW)      state_next = ST_MEMRD;
        else if (op == OP_SW) state_next = ST_MEMWR;
        else                  state_next = ST_FETCH;
      end
      ST_MEMRD:  state_next = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_next = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_next = ST_ALUWB;
      ST_ADDIEX: state_next = ST_ADDIWB;
      // Single-cycle tail states and any undefined encoding return to FETCH.
      default:   state_next = ST_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_reg),
    .opcode    (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_dec)
  );

  // Reset masks the control word immediately, not just from the next edge.
  assign ctrl_out = rst ? '0 : ctrl_dec;
  assign state_o  = rst ? ST_W'(ST_FETCH) : ST_W'(state_reg);

  assign mem_req    = ctrl_out.mem_req;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign reg_write  = ctrl_out.reg_write;
  assign iord       = ctrl_out.iord;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign pc_src     = ctrl_out.pc_src;
  assign pc_en      = ctrl_out.pc_en;
  assign alu_op     = ctrl_out.alu_op;
  assign illegal_op = ctrl_out.illegal_op;

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: self-checking bench for mc_main_control.
// A transaction-level model predicts, per instruction, its latency and how
// many cycles each control event occurs, given the opcode, zero and the
// number of wait cycles the bench inserts into each memory access.
module tb_mc_main_control;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, ir_write, reg_write, iord, alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_dst, mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [1:0] alu_op;
  logic       illegal_op;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  mc_main_control #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .pc_en(pc_en), .alu_op(alu_op), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] all_outs();
    return {mem_req, mem_write, ir_write, reg_write, iord, alu_src_a, alu_src_b,
            reg_dst, mem_to_reg, pc_src, pc_en, alu_op, illegal_op};
  endfunction

  // Reset asserted for 3 cycles while an LW sits in MEMRD.
  task automatic test_reset();
    bit reached = 0;
    opcode = OP_LW;
    for (int i = 0; i < 10 && !reached; i++) begin
      @(negedge clk);
      if (state_o === ST_MEMRD) begin
        reached = 1;
        mem_ready = 1'b0;
      end else mem_ready = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reset_reach_memrd: state=%0d required=%0d", state_o, ST_MEMRD);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (all_outs() !== 16'h0 || state_o !== ST_FETCH) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: outs=%h state=%0d required outs=0000 state=%0d",
                 k, all_outs(), state_o, ST_FETCH);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== ST_FETCH || mem_req !== 1'b1 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d mem_req=%b reg_write=%b required state=%0d mem_req=1 reg_write=0",
               state_o, mem_req, reg_write, ST_FETCH);
    end
    $display("test_reset: done");
  endtask

  // LW with memory always ready: exact state walk, writeback only in MEMWB.
  task automatic test_lw_sequence();
    state_t exp_seq [6] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_FETCH};
    opcode = OP_LW;
    zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = (i < 5);
      #1;
      checks++;
      if (state_o !== exp_seq[i]) begin
        errors++;
        $display("FAIL lw_state step%0d: state=%0d required=%0d", i, state_o, exp_seq[i]);
      end
      if (i < 5) begin
        checks++;
        if (reg_write !== (i == 4) ||
            (i == 4 && (mem_to_reg !== 1'b1 || reg_dst !== 1'b0))) begin
          errors++;
          $display("FAIL lw_writeback step%0d: reg_write=%b mem_to_reg=%b reg_dst=%b required reg_write=%b",
                   i, reg_write, mem_to_reg, reg_dst, (i == 4));
        end
      end
    end
    $display("test_lw_sequence: done");
  endtask

  // One instruction with given opcode, zero and wait-cycle counts for the
  // fetch access and (if any) the data access. Starts and ends in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int s_fetch, input int s_data);
    int   cyc = 0, stall, n_rw = 0, n_mw = 0, n_req = 0, n_ir = 0;
    int   n_pc = 0, n_ill = 0, n_rt = 0;
    int   e_lat, e_rw, e_mw, e_req, e_pc, e_ill, e_rt;
    bit   left = 0, done = 0, ill_bad = 0, fetch_pcs_bad = 0;
    logic [1:0] wb_sel = 2'b00, br_pcs = 2'b00, e_wb, e_brpcs;
    bit   is_mem, legal;

    legal  = 1;
    is_mem = (op == OP_LW || op == OP_SW);
    e_rw = 0; e_mw = 0; e_pc = 1; e_rt = 0; e_wb = 2'b00; e_brpcs = 2'b00;
    case (op)
      OP_LW:    begin e_lat = 5; e_rw = 1; e_wb = 2'b01; end
      OP_SW:    begin e_lat = 4; e_mw = s_data + 1; end
      OP_RTYPE: begin e_lat = 4; e_rw = 1; e_rt = 1; e_wb = 2'b10; end
      OP_ADDI:  begin e_lat = 4; e_rw = 1; end
      OP_BEQ:   begin e_lat = 3; e_pc += z; e_brpcs = z ? PCSRC_ALUOUT : 2'b00; end
      OP_J:     begin e_lat = 3; e_pc += 1; e_brpcs = PCSRC_JUMP; end
`ifdef MC_MAIN_CONTROL_BNE_EN
      OP_BNE:   begin e_lat = 3; e_pc += !z; e_brpcs = !z ? PCSRC_ALUOUT : 2'b00; end
`endif
      default:  begin e_lat = 2; legal = 0; end
    endcase
    e_lat += s_fetch + (is_mem ? s_data : 0);
    e_req  = s_fetch + 1 + (is_mem ? s_data + 1 : 0);
    e_ill  = legal ? 0 : 1;

    opcode = op;
    zero   = z;
    stall  = s_fetch;
    while (!done) begin
      @(negedge clk);
      if (left && state_o === ST_FETCH) begin
        done = 1;
      end else if (cyc >= 40) begin
        done = 1;
        e_lat = -1;
        $display("FAIL timeout op=%b: no return to FETCH within 40 cycles", op);
      end else begin
        if (state_o !== ST_FETCH) left = 1;
        if (mem_req) begin
          if (stall > 0) begin mem_ready = 1'b0; stall--; end
          else begin mem_ready = 1'b1; stall = s_data; end
        end else mem_ready = 1'($urandom_range(0, 1));
        #1;
        n_rw  += reg_write;
        n_mw  += (mem_write && mem_req);
        n_req += mem_req;
        n_ir  += ir_write;
        n_pc  += pc_en;
        n_ill += illegal_op;
        n_rt  += (alu_op == ALUOP_RTYPE);
        if (illegal_op && state_o !== ST_DECODE) ill_bad = 1;
        if (reg_write) wb_sel = {reg_dst, mem_to_reg};
        if (pc_en && ir_write && pc_src !== PCSRC_ALU) fetch_pcs_bad = 1;
        if (pc_en && !ir_write) br_pcs = pc_src;
        cyc++;
      end
    end
    mem_ready = 1'b0;

    checks++;
    if (cyc !== e_lat) begin errors++; $display("FAIL latency op=%b: got %0d required %0d", op, cyc, e_lat); end
    checks++;
    if (n_rw !== e_rw) begin errors++; $display("FAIL reg_write_count op=%b: got %0d required %0d", op, n_rw, e_rw); end
    checks++;
    if (n_mw !== e_mw) begin errors++; $display("FAIL mem_write_count op=%b: got %0d required %0d", op, n_mw, e_mw); end
    checks++;
    if (n_req !== e_req) begin errors++; $display("FAIL mem_req_count op=%b: got %0d required %0d", op, n_req, e_req); end
    checks++;
    if (n_ir !== 1) begin errors++; $display("FAIL ir_write_count op=%b: got %0d required 1", op, n_ir); end
    checks++;
    if (n_pc !== e_pc) begin errors++; $display("FAIL pc_en_count op=%b z=%b: got %0d required %0d", op, z, n_pc, e_pc); end
    checks++;
    if (n_ill !== e_ill || ill_bad) begin errors++; $display("FAIL illegal_op op=%b: got %0d (outside DECODE=%0d) required %0d", op, n_ill, ill_bad, e_ill); end
    checks++;
    if (n_rt !== e_rt) begin errors++; $display("FAIL aluop_rtype_count op=%b: got %0d required %0d", op, n_rt, e_rt); end
    checks++;
    if (wb_sel !== e_wb) begin errors++; $display("FAIL wb_select op=%b: {reg_dst,mem_to_reg}=%b required %b", op, wb_sel, e_wb); end
    checks++;
    if (br_pcs !== e_brpcs || fetch_pcs_bad) begin errors++; $display("FAIL pc_src op=%b: got %b (fetch bad=%0d) required %b", op, br_pcs, fetch_pcs_bad, e_brpcs); end
    $display("instr op=%b zero=%b stalls=%0d/%0d latency=%0d", op, z, s_fetch, s_data, cyc);
  endtask

  task automatic test_directed();
    run_instr(OP_SW, 1'b0, 0, 2);      // mem_write held 3 cycles
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 1, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(OP_BNE, 1'b0, 0, 0);     // illegal or BNE depending on build
    run_instr(OP_BNE, 1'b1, 0, 0);
    run_instr(OP_ADDI, 1'b1, 2, 0);
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 1, 3);
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE, 6'b111111};
    logic [5:0] op;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== 16'h0 || state_o !== ST_FETCH) begin
      errors++;
      $display("FAIL poweron_reset: outs=%h state=%0d required outs=0000 state=%0d",
               all_outs(), state_o, ST_FETCH);
    end
    rst = 1'b0;
    test_lw_sequence();
    test_reset();
    test_directed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
